puf_eval_ctrl: RTL and testbench

//  Sequencer that drives the arbiter PUF: applies a challenge to the delay chain,

---
 rtl/puf_eval_ctrl_pkg.sv | 16 +
 rtl/puf_eval_ctrl_sync_2ff.sv | 24 ++
 rtl/puf_eval_ctrl.sv | 151 +++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_eval_ctrl_pkg.sv
// Shared definitions for the arbiter-PUF evaluation sequencer: state encoding and
// default challenge width / LFSR feedback mask shared with the arbiter top.
package puf_eval_ctrl_pkg;

    localparam int unsigned ChalWDefault = 64;
    localparam logic [63:0] LfsrTapsDefault = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPrechg = 3'd1,
        StLaunch = 3'd2,
        StDecide = 3'd3,
        StDone   = 3'd4
    } puf_state_e;

endpackage

// File: rtl/puf_eval_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous arbiter output into the clk domain.
module puf_eval_ctrl_sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF sequencer: precharge/launch races per challenge, majority-vote N_EVAL races
// into one response bit, step the challenge via Galois LFSR, and publish RESP_W bits.
module puf_eval_ctrl
    import puf_eval_ctrl_pkg::*;
#(
    parameter int unsigned          CHAL_W     = ChalWDefault,
    parameter int unsigned          RESP_W     = 8,
    parameter int unsigned          N_EVAL     = 5,
    parameter int unsigned          SETTLE_CYC = 4,
    parameter logic [CHAL_W-1:0]    LFSR_TAPS  = LfsrTapsDefault[CHAL_W-1:0]
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CHAL_W-1:0]   seed,
    input  logic                arb_q,
    output logic [CHAL_W-1:0]   challenge,
    output logic                race_en,
    output logic                busy,
    output logic                done,
    output logic [RESP_W-1:0]   response
);

    localparam int unsigned CntW = $clog2(N_EVAL + 1);
    localparam int unsigned BitW = $clog2(RESP_W);
    localparam int unsigned TmrW = $clog2(SETTLE_CYC + 3);

    localparam logic [TmrW-1:0] PrechgLast = TmrW'(SETTLE_CYC - 1);
    localparam logic [TmrW-1:0] LaunchLast = TmrW'(SETTLE_CYC + 1);
    localparam logic [CntW-1:0] EvalLast   = CntW'(N_EVAL - 1);
    localparam logic [CntW-1:0] Majority   = CntW'(N_EVAL / 2);
    localparam logic [BitW-1:0] BitLast    = BitW'(RESP_W - 1);

    puf_state_e          state_q, state_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [TmrW-1:0]     tmr_q, tmr_d;
    logic [CntW-1:0]     eval_q, eval_d;
    logic [CntW-1:0]     ones_q, ones_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [RESP_W-1:0]   resp_sr_q, resp_sr_d;
    logic [RESP_W-1:0]   response_q, response_d;
    logic                done_q, done_d;
    logic                arb_sync;

    puf_eval_ctrl_sync_2ff u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (arb_q),
        .q_o    (arb_sync)
    );

    always_comb begin
        state_d    = state_q;
        chal_d     = chal_q;
        tmr_d      = tmr_q;
        eval_d     = eval_q;
        ones_d     = ones_q;
        bit_d      = bit_q;
        resp_sr_d  = resp_sr_q;
        response_d = response_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // An all-zero seed would lock the LFSR at zero.
                    chal_d    = (seed == '0) ? CHAL_W'(1) : seed;
                    tmr_d     = '0;
                    eval_d    = '0;
                    ones_d    = '0;
                    bit_d     = '0;
                    resp_sr_d = '0;
                    state_d   = StPrechg;
                end
            end
            StPrechg: begin
                if (tmr_q == PrechgLast) begin
                    tmr_d   = '0;
                    state_d = StLaunch;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StLaunch: begin
                // Last cycle covers the race resolve plus the synchronizer delay.
                if (tmr_q == LaunchLast) begin
                    tmr_d  = '0;
                    ones_d = ones_q + CntW'(arb_sync);
                    if (eval_q == EvalLast) begin
                        eval_d  = '0;
                        state_d = StDecide;
                    end else begin
                        eval_d  = eval_q + 1'b1;
                        state_d = StPrechg;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StDecide: begin
                resp_sr_d = {resp_sr_q[RESP_W-2:0], (ones_q > Majority)};
                ones_d    = '0;
                chal_d    = (chal_q >> 1) ^ (chal_q[0] ? LFSR_TAPS : '0);
                if (bit_q == BitLast) begin
                    state_d = StDone;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    state_d = StPrechg;
                end
            end
            StDone: begin
                response_d = resp_sr_q;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            chal_q     <= '0;
            tmr_q      <= '0;
            eval_q     <= '0;
            ones_q     <= '0;
            bit_q      <= '0;
            resp_sr_q  <= '0;
            response_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chal_q     <= chal_d;
            tmr_q      <= tmr_d;
            eval_q     <= eval_d;
            ones_q     <= ones_d;
            bit_q      <= bit_d;
            resp_sr_q  <= resp_sr_d;
            response_q <= response_d;
            done_q     <= done_d;
        end
    end

    // Decoded from the async-reset state so race_en drops immediately on reset.
    assign race_en   = (state_q == StLaunch);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign challenge = chal_q;
    assign response  = response_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl with a behavioural arbiter model and a response
// scoreboard filled at start and drained on done.
module tb_puf_eval_ctrl;

    localparam logic [63:0] Taps    = 64'hD800_0000_0000_0000;
    localparam int          ExpLat  = 409;
    localparam int          Bit1Cyc = 52;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] seed;
    logic        arb_q;
    logic [63:0] challenge;
    logic        race_en;
    logic        busy;
    logic        done;
    logic [7:0]  response;

    int n_checks = 0;
    int n_fail   = 0;

    int   arb_mode = 0;
    int   race_cnt = 0;
    logic race_clr = 1'b0;
    logic race_en_prev = 1'b0;
    logic pattern;
    logic [7:0] sb[$];

    puf_eval_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .arb_q     (arb_q),
        .challenge (challenge),
        .race_en   (race_en),
        .busy      (busy),
        .done      (done),
        .response  (response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter model: mode 0 tied low, 1 tied high, 2 fixed 3-of-5 / 2-of-5 vote pattern,
    // 3 outcome is the parity of the applied challenge.
    assign pattern = ((race_cnt / 5) < 4) ? ((race_cnt % 5) < 3) : ((race_cnt % 5) < 2);
    assign arb_q = (arb_mode == 1) ? 1'b1 :
                   race_en & ((arb_mode == 2) ? pattern :
                              (arb_mode == 3) ? ^challenge : 1'b0);

    always @(negedge clk) begin
        if (race_clr) race_cnt <= 0;
        else if (race_en_prev && !race_en) race_cnt <= race_cnt + 1;
        race_en_prev <= race_en;
    end

    function automatic logic [63:0] lfsr_step(input logic [63:0] c);
        return (c >> 1) ^ (c[0] ? Taps : 64'h0);
    endfunction

    function automatic logic [7:0] model_resp(input logic [63:0] s, input int mode);
        logic [63:0] c;
        logic [7:0]  r;
        logic        b;
        c = (s == 64'h0) ? 64'h1 : s;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       b = 1'b0;
                1:       b = 1'b1;
                2:       b = (i < 4);
                default: b = ^c;
            endcase
            r = {r[6:0], b};
            c = lfsr_step(c);
        end
        return r;
    endfunction

    task automatic run_one(input logic [63:0] s, input int mode, input int extra_at,
                           output int lat, output int viol,
                           output logic [63:0] chal_first, output logic [63:0] chal_bit1);
        int          cyc;
        logic        prev_re;
        logic [63:0] prev_ch;
        logic [7:0]  exp_r;
        arb_mode = mode;
        seed     = s;
        race_clr = 1'b1;
        @(negedge clk);
        #1 race_clr = 1'b0;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(model_resp(s, mode));
        viol = 0;
        chal_first = 64'h0;
        chal_bit1 = 64'h0;
        cyc = 0;
        prev_re = 1'b0;
        prev_ch = challenge;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_at);
            if (cyc == 1) chal_first = challenge;
            if (cyc == Bit1Cyc) chal_bit1 = challenge;
            if (prev_re && race_en && challenge !== prev_ch) viol++;
            prev_re = race_en;
            prev_ch = challenge;
        end while (!done && cyc < 1000);
        start = 1'b0;
        lat = cyc - 1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
            sb.delete();
        end else begin
            exp_r = sb.pop_front();
            n_checks++;
            if (response !== exp_r) begin
                n_fail++;
                $display("FAIL response: got %h expected %h", response, exp_r);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        seed  = 64'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({challenge, race_en, busy, done, response} !== 75'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: chal=%h race_en=%b busy=%b done=%b resp=%h",
                     challenge, race_en, busy, done, response);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || race_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b race_en=%b expected 0 0 0",
                     busy, done, race_en);
        end
    endtask

    task automatic test_all_ones();
        int lat, viol;
        logic [63:0] c0, c1;
        run_one(64'h1, 1, 0, lat, viol, c0, c1);
        n_checks++;
        if (lat !== ExpLat) begin
            n_fail++;
            $display("FAIL ones_latency: got %0d expected %0d", lat, ExpLat);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_done: got %b expected 0", busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_all_zeros();
        int lat, viol;
        logic [63:0] c0, c1;
        logic [63:0] s;
        s = 64'hA5A5_0000_FFFF_1234;
        run_one(s, 0, 0, lat, viol, c0, c1);
        n_checks++;
        if (c0 !== s) begin
            n_fail++;
            $display("FAIL zeros_first_chal: got %h expected %h", c0, s);
        end
        n_checks++;
        if (c1 !== lfsr_step(s)) begin
            n_fail++;
            $display("FAIL zeros_chal_bit1: got %h expected %h", c1, lfsr_step(s));
        end
    endtask

    task automatic test_majority();
        int lat, viol;
        logic [63:0] c0, c1;
        run_one(64'h0123_4567_89AB_CDEF, 2, 0, lat, viol, c0, c1);
        n_checks++;
        if (lat !== ExpLat) begin
            n_fail++;
            $display("FAIL majority_latency: got %0d expected %0d", lat, ExpLat);
        end
    endtask

    task automatic test_seed_zero();
        int lat, viol;
        logic [63:0] c0, c1;
        run_one(64'h0, 3, 0, lat, viol, c0, c1);
        n_checks++;
        if (c0 !== 64'h1) begin
            n_fail++;
            $display("FAIL seed0_first_chal: got %h expected %h", c0, 64'h1);
        end
        n_checks++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL chal_stable_in_race: got %0d changes expected 0", viol);
        end
        n_checks++;
        if (c1 !== 64'hD800_0000_0000_0000) begin
            n_fail++;
            $display("FAIL seed0_chal_bit1: got %h expected %h", c1, Taps);
        end
    endtask

    task automatic test_busy_and_reset();
        int lat, viol, extra_dones, cyc;
        logic [63:0] c0, c1;
        run_one(64'hDEAD_BEEF_0000_0001, 1, 100, lat, viol, c0, c1);
        n_checks++;
        if (lat !== ExpLat) begin
            n_fail++;
            $display("FAIL busy_start_latency: got %0d expected %0d", lat, ExpLat);
        end
        extra_dones = 0;
        repeat (450) begin
            @(negedge clk);
            if (done) extra_dones++;
        end
        n_checks++;
        if (extra_dones !== 0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got %0d extra done expected 0", extra_dones);
        end

        arb_mode = 3;
        seed = 64'h1357_9BDF_2468_ACE0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!race_en && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (race_en !== 1'b1) begin
            n_fail++;
            $display("FAIL launch_timeout: race_en=%b expected 1", race_en);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (race_en !== 1'b0 || busy !== 1'b0 || response !== 8'h00 || challenge !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset: race_en=%b busy=%b resp=%h chal=%h expected all 0",
                     race_en, busy, response, challenge);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(64'h1357_9BDF_2468_ACE0, 3, 0, lat, viol, c0, c1);
        n_checks++;
        if (lat !== ExpLat) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d expected %0d", lat, ExpLat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        seed  = 64'h0;
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_majority();
        test_seed_zero();
        test_busy_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
